// File: rtl/operand_fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | operand_fetch_unit_if: request, register-file, memory, writeback and      |
// | operand-output signals of the operand fetch stage.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface operand_fetch_unit_if #(
  parameter int DW   = 8,
  parameter int NREG = 32,
  parameter int SELW = 6
);
  logic [NREG*DW-1:0] regfile;
  logic [DW-1:0]      instr;
  logic [DW-1:0]      dataout_mem;
  logic               mem_valid;
  logic               req_valid;
  logic               req_ready;
  logic [SELW-1:0]    src1sel;
  logic [SELW-1:0]    src2sel;
  logic               wb_en;
  logic [SELW-1:0]    wb_sel;
  logic [DW-1:0]      wb_data;
  logic               op_valid;
  logic               op_ready;
  logic [DW-1:0]      src1out;
  logic [DW-1:0]      src2out;

  modport master (
    output regfile, instr, dataout_mem, mem_valid, req_valid, src1sel, src2sel,
           wb_en, wb_sel, wb_data, op_ready,
    input  req_ready, op_valid, src1out, src2out
  );

  modport slave (
    input  regfile, instr, dataout_mem, mem_valid, req_valid, src1sel, src2sel,
           wb_en, wb_sel, wb_data, op_ready,
    output req_ready, op_valid, src1out, src2out
  );
endinterface
`default_nettype wire

// File: rtl/operand_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | operand_fetch_unit: registered two-operand fetch with memory wait and a  |
// | one-entry valid/ready output. Define OPFETCH_BYPASS_EN for wb bypass.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module operand_fetch_unit #(
  parameter int DW   = 8,
  parameter int NREG = 32,
  parameter int SELW = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_fetch_unit_if.slave  bus
);

  localparam logic [1:0]      c_ST_IDLE     = 2'd0;
  localparam logic [1:0]      c_ST_WAIT_MEM = 2'd1;
  localparam logic [1:0]      c_ST_FULL     = 2'd2;
  localparam logic [SELW-1:0] c_SEL_MEM     = SELW'(NREG);
  localparam logic [SELW-1:0] c_SEL_IMM     = SELW'(NREG + 1);

  logic [1:0]      state_q, state_d;
  logic [DW-1:0]   src1out_q, src1out_d;
  logic [DW-1:0]   src2out_q, src2out_d;
  logic [SELW-1:0] sel1_q, sel1_d;
  logic [SELW-1:0] sel2_q, sel2_d;
  logic [DW-1:0]   instr_q, instr_d;

  logic            w_req_ready;
  logic            w_op_valid;
  logic            w_accept;
  logic            w_needs_wait;
  logic [SELW-1:0] w_dec_sel1;
  logic [SELW-1:0] w_dec_sel2;
  logic [DW-1:0]   w_dec_imm;
  logic            w_byp1;
  logic            w_byp2;
  logic [DW-1:0]   w_op1;
  logic [DW-1:0]   w_op2;

  function automatic logic [DW-1:0] decode_sel(
    input logic [SELW-1:0]    sel,
    input logic [DW-1:0]      imm,
    input logic [NREG*DW-1:0] rf,
    input logic [DW-1:0]      mem,
    input logic               byp_hit,
    input logic [DW-1:0]      byp_data
  );
    logic [DW-1:0] val;
    val = '0;
    if (sel == c_SEL_MEM) begin
      val = mem;
    end else if (sel == c_SEL_IMM) begin
      val = imm;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (sel == SELW'(k)) begin
          val = byp_hit ? byp_data : rf[k*DW +: DW];
        end
      end
    end
    return val;
  endfunction

  // A parked request decodes from its captured selectors and immediate.
  assign w_dec_sel1 = (state_q == c_ST_WAIT_MEM) ? sel1_q  : bus.src1sel;
  assign w_dec_sel2 = (state_q == c_ST_WAIT_MEM) ? sel2_q  : bus.src2sel;
  assign w_dec_imm  = (state_q == c_ST_WAIT_MEM) ? instr_q : bus.instr;

`ifdef OPFETCH_BYPASS_EN
  assign w_byp1 = bus.wb_en && (bus.wb_sel == w_dec_sel1);
  assign w_byp2 = bus.wb_en && (bus.wb_sel == w_dec_sel2);
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{bus.wb_en, bus.wb_sel, bus.wb_data};
  assign w_byp1      = 1'b0;
  assign w_byp2      = 1'b0;
`endif

  assign w_op1 = decode_sel(w_dec_sel1, w_dec_imm, bus.regfile, bus.dataout_mem, w_byp1, bus.wb_data);
  assign w_op2 = decode_sel(w_dec_sel2, w_dec_imm, bus.regfile, bus.dataout_mem, w_byp2, bus.wb_data);

  assign w_accept     = bus.req_valid && w_req_ready;
  assign w_needs_wait = ((bus.src1sel == c_SEL_MEM) || (bus.src2sel == c_SEL_MEM)) && !bus.mem_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_ST_IDLE;
      src1out_q <= '0;
      src2out_q <= '0;
      sel1_q    <= '0;
      sel2_q    <= '0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      src1out_q <= src1out_d;
      src2out_q <= src2out_d;
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
      instr_q   <= instr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src1out_d = src1out_q;
    src2out_d = src2out_q;
    sel1_d    = sel1_q;
    sel2_d    = sel2_q;
    instr_d   = instr_q;
    case (state_q)
      c_ST_IDLE, c_ST_FULL: begin
        if (w_accept) begin
          if (w_needs_wait) begin
            state_d = c_ST_WAIT_MEM;
            sel1_d  = bus.src1sel;
            sel2_d  = bus.src2sel;
            instr_d = bus.instr;
          end else begin
            state_d   = c_ST_FULL;
            src1out_d = w_op1;
            src2out_d = w_op2;
          end
        end else if ((state_q == c_ST_FULL) && bus.op_ready) begin
          state_d = c_ST_IDLE;
        end
      end
      c_ST_WAIT_MEM: begin
        if (bus.mem_valid) begin
          state_d   = c_ST_FULL;
          src1out_d = w_op1;
          src2out_d = w_op2;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = (state_q == c_ST_IDLE) || ((state_q == c_ST_FULL) && bus.op_ready);
    w_op_valid  = (state_q == c_ST_FULL);
  end

  assign bus.req_ready = w_req_ready;
  assign bus.op_valid  = w_op_valid;
  assign bus.src1out   = src1out_q;
  assign bus.src2out   = src2out_q;

endmodule
`default_nettype wire
